// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive sides.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 8;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP  = 3'd4,
        ACK   = 3'd5
    } uart_state_e;
endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: requester/transmitter handshake plus the serial line.
interface uart_transmitter_if;
    import uart_pkg::*;
    logic                 XMIT_REQ;
    logic [DATA_BITS-1:0] XMIT_DATA;
    logic                 XMIT_ACK;
    logic                 XMIT_BUSY;
    logic                 XMT;
    modport master(output XMIT_REQ, XMIT_DATA, input XMIT_ACK, XMIT_BUSY, XMT);
    modport slave(input XMIT_REQ, XMIT_DATA, output XMIT_ACK, XMIT_BUSY, XMT);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every CLKS_PER_BIT cycles, phase-aligned by restart.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic clr_n,
    input  logic restart,
    output logic tick
);
    logic [7:0] cnt;
    assign tick = cnt == 8'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (!clr_n || restart || tick) cnt <= '0;
        else cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serial byte transmitter with a four-phase REQ/ACK handshake.
// Define UART_TX_PARITY_EN to send an even-parity bit between data and stop bits.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input logic clk,
    input logic clr_n,
    uart_transmitter_if.slave bus
);
    uart_state_e          state;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           idx;
    logic                 stop_cnt, xmt, ack, busy, tick, restart;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif
    // Restarting on acceptance makes every frame's bit timing start fresh.
    assign restart = state == IDLE && bus.XMIT_REQ;
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk(clk), .clr_n(clr_n), .restart(restart), .tick(tick)
    );
    assign bus.XMT       = xmt;
    assign bus.XMIT_ACK  = ack;
    assign bus.XMIT_BUSY = busy;
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            xmt      <= 1'b1;
            ack      <= 1'b0;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    xmt  <= 1'b1;
                    ack  <= 1'b0;
                    busy <= 1'b0;
                    if (bus.XMIT_REQ) begin
                        state <= START;
                        shreg <= bus.XMIT_DATA;
                        xmt   <= 1'b0;
                        busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par   <= ^bus.XMIT_DATA;
`endif
                    end
                end
                START: if (tick) begin
                    state <= DATA;
                    idx   <= '0;
                    xmt   <= shreg[0];
                    shreg <= shreg >> 1;
                end
                DATA: if (tick) begin
                    if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        xmt   <= par;
`else
                        state    <= STOP;
                        xmt      <= 1'b1;
                        stop_cnt <= 1'b0;
`endif
                    end else begin
                        idx   <= idx + 3'd1;
                        xmt   <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (tick) begin
                    state    <= STOP;
                    xmt      <= 1'b1;
                    stop_cnt <= 1'b0;
                end
`endif
                STOP: if (tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end else stop_cnt <= 1'b1;
                end
                ACK: if (!bus.XMIT_REQ) begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    xmt   <= 1'b1;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: table-driven and randomized frames checked cycle by cycle
// against a frame model built from the serial format rules.
module tb_uart_transmitter;
    import uart_pkg::*;
    localparam int C = DEFAULT_CLKS_PER_BIT;
    localparam int S = 1;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L = 9 + S + P;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int tests = 0;
    int fails = 0;

    uart_transmitter_if bus();
    uart_transmitter #(.CLKS_PER_BIT(C), .STOP_BITS(S)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       pulse;
        int         extra;
    } vec_t;
    typedef logic bitq_t[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_xmt"}, bus.XMT, 1'b1);
        check({tag, "_ack"}, bus.XMIT_ACK, 1'b0);
        check({tag, "_busy"}, bus.XMIT_BUSY, 1'b0);
    endtask

    function automatic bitq_t frame_bits(input logic [7:0] d, input logic par);
        bitq_t fr;
        fr.push_back(1'b0);
        for (int i = 0; i < 8; i++) fr.push_back(d[i]);
        if (P == 1) fr.push_back(par);
        for (int i = 0; i < S; i++) fr.push_back(1'b1);
        return fr;
    endfunction

    function automatic logic even_par(input logic [7:0] d);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        return logic'(n % 2);
    endfunction

    // Caller has set REQ/DATA at a negedge; the next posedge is acceptance edge k.
    task automatic run_frame(input logic [7:0] d, input logic par, input logic pulse,
                             input int extra, input logic noisy);
        bitq_t fr = frame_bits(d, par);
        cycle();
        for (int t = 0; t < L * C; t++) begin
            check($sformatf("xmt_%02h_t%0d", d, t), bus.XMT, fr[t / C]);
            check($sformatf("busy_%02h_t%0d", d, t), bus.XMIT_BUSY, 1'b1);
            check($sformatf("ack_early_%02h_t%0d", d, t), bus.XMIT_ACK, 1'b0);
            bus.XMIT_REQ = (noisy && t != L * C - 1) ? 1'($urandom) : !pulse;
            if (noisy) bus.XMIT_DATA = 8'($urandom);
            cycle();
        end
        check($sformatf("ack_rise_%02h", d), bus.XMIT_ACK, 1'b1);
        check($sformatf("ack_xmt_%02h", d), bus.XMT, 1'b1);
        check($sformatf("ack_busy_%02h", d), bus.XMIT_BUSY, 1'b1);
        for (int i = 0; i < (pulse ? 0 : extra); i++) begin
            cycle();
            check($sformatf("ack_hold_%02h_%0d", d, i), bus.XMIT_ACK, 1'b1);
            check($sformatf("ack_hold_xmt_%02h_%0d", d, i), bus.XMT, 1'b1);
        end
        bus.XMIT_REQ = 1'b0;
        cycle();
        check_idle($sformatf("ack_drop_%02h", d));
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic pulse,
                        input int extra, input logic noisy);
        bus.XMIT_REQ = 1'b1;
        bus.XMIT_DATA = d;
        run_frame(d, par, pulse, extra, noisy);
    endtask

    initial begin
        bus.XMIT_REQ = 1'b0;
        bus.XMIT_DATA = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_idle($sformatf("rst_%0d", i));
        end
        clr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_idle($sformatf("post_rst_%0d", i));
        end

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 0};
        vecs[1] = '{8'h07, 1'b1, 1'b1, 0};
        vecs[2] = '{8'h03, 1'b0, 1'b0, 2};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 200 - L * C};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 0};
        vecs[6] = '{8'h80, 1'b1, 1'b0, 3};
        vecs[7] = '{8'h55, 1'b0, 1'b1, 0};
        // Frames run back to back: REQ is re-raised on each ACK-drop cycle.
        for (int i = 0; i < 8; i++) send(vecs[i].data, vecs[i].par, vecs[i].pulse, vecs[i].extra, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_idle($sformatf("quiet_%0d", i));
        end

        // Abort a 0x55 frame with reset sampled at edge k+35.
        bus.XMIT_REQ = 1'b1;
        bus.XMIT_DATA = 8'h55;
        cycle();
        bus.XMIT_REQ = 1'b0;
        for (int t = 1; t <= 34; t++) cycle();
        check("abort_pre_xmt", bus.XMT, 1'b0);
        clr_n = 1'b0;
        cycle();
        check_idle("abort_0");
        cycle();
        check_idle("abort_1");
        clr_n = 1'b1;
        for (int i = 0; i < 12 * C; i++) begin
            cycle();
            check_idle($sformatf("abort_after_%0d", i));
        end
        send(8'h55, 1'b0, 1'b1, 0, 1'b0);

        // REQ held high through reset is taken on the first edge out of reset.
        clr_n = 1'b0;
        bus.XMIT_REQ = 1'b1;
        bus.XMIT_DATA = 8'h3C;
        cycle();
        check_idle("req_in_rst_0");
        cycle();
        check_idle("req_in_rst_1");
        clr_n = 1'b1;
        run_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send(d, even_par(d), 1'($urandom), int'($urandom_range(0, 4)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
